modn_down_counter: RTL and testbench



---
 rtl/modn_down_counter.sv | 134 +++++++++++++
 tb/tb_modn_down_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/modn_down_counter.sv
// -----------------------------------------------------------------------------
// modn_down_counter
//
// Loadable modulo-n down counter. It counts from a loaded value (clamped to
// n-1) down to 0. At 0 it either wraps back to n-1 (auto-reload) or stops
// and raises done (one-shot). The combinational tc strobe lets stages be
// cascaded: one stage's tc drives the next stage's en.
//
// Parameters:
//   x         counter width in bits
//   n         modulus, count range 0..n-1, 2 <= n <= 2**x
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-high reset
//   en        in   1  count enable (ignored outside RUN)
//   load      in   1  synchronous load strobe, has priority over en
//   load_val  in   x  value to load (values above n-1 clamp to n-1)
//   one_shot  in   1  mode captured on load: 1 = stop at 0, 0 = auto-reload
//   count     out  x  current count, registered
//   tc        out  1  terminal count: RUN & en & count==0, combinational
//   busy      out  1  state is RUN, registered
//   done      out  1  state is DONE, registered
// -----------------------------------------------------------------------------
module modn_down_counter #(
   parameter int x = 3,
   parameter int n = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [x-1:0] load_val,
   input  logic         one_shot,
   output logic [x-1:0] count,
   output logic         tc,
   output logic         busy,
   output logic         done
);

   localparam logic [x-1:0] cnt_zero = {x{1'b0}};
   localparam logic [x-1:0] cnt_one  = x'(1);
   localparam logic [x-1:0] cnt_max  = x'(n - 1);

   // 2'b11 is unused; it falls into the default branch and recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t       state_q, state_d;
   logic [x-1:0] count_q, count_d;
   logic         mode_q,  mode_d;
   logic         busy_q,  busy_d;
   logic         done_q,  done_d;

   // Out-of-range load values saturate at the top of the count range.
   function automatic logic [x-1:0] clamp_load(input logic [x-1:0] v);
      if (v > cnt_max) begin
         clamp_load = cnt_max;
      end else begin
         clamp_load = v;
      end
   endfunction

   // Next-state, next-count and next-mode logic; load overrides everything.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      if (load) begin
         count_d = clamp_load(load_val);
         mode_d  = one_shot;
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RUN: begin
               if (en) begin
                  if (count_q == cnt_zero) begin
                     if (mode_q) begin
                        // One-shot expiry: count parks at 0.
                        state_d = ST_DONE;
                     end else begin
                        count_d = cnt_max;
                     end
                  end else begin
                     count_d = count_q - cnt_one;
                  end
               end else begin
                  count_d = count_q;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = cnt_zero;
               mode_d  = 1'b0;
            end
         endcase
      end
      // Status flags are registered copies of the next state.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State, count, mode and status registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count_q <= cnt_zero;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign tc    = (state_q == ST_RUN) & en & (count_q == cnt_zero);

endmodule

// File: tb/tb_modn_down_counter.sv
module tb_modn_down_counter;

   logic       clk;
   logic       reset;
   logic       en, load, one_shot;
   logic [2:0] load_val;
   logic [2:0] count;
   logic       tc, busy, done;

   // cascade pair
   logic       c_load;
   logic [2:0] c_lv;
   logic       c_os;
   logic       c1_en;
   logic [2:0] c1_count, c2_count;
   logic       c1_tc, c1_busy, c1_done;
   logic       c2_tc, c2_busy, c2_done;

   modn_down_counter #(.x(3), .n(6)) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .one_shot(one_shot), .count(count), .tc(tc), .busy(busy), .done(done)
   );

   modn_down_counter #(.x(3), .n(6)) u_c1 (
      .clk(clk), .reset(reset), .en(c1_en), .load(c_load), .load_val(c_lv),
      .one_shot(c_os), .count(c1_count), .tc(c1_tc), .busy(c1_busy), .done(c1_done)
   );

   modn_down_counter #(.x(3), .n(6)) u_c2 (
      .clk(clk), .reset(reset), .en(c1_tc), .load(c_load), .load_val(c_lv),
      .one_shot(c_os), .count(c2_count), .tc(c2_tc), .busy(c2_busy), .done(c2_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         sel;
      logic [2:0] cnt;
      logic       tc;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   event chk_ev;

   task automatic push(input int sel, input logic [2:0] c, input logic t,
                       input logic b, input logic d, input string nm);
      exp_t e;
      e.sel = sel; e.cnt = c; e.tc = t; e.busy = b; e.done = d; e.name = nm;
      sb_q.push_back(e);
   endtask

   // Monitor: on each falling edge (or an explicit mid-cycle request) compare
   // every pending expectation against the selected instance.
   initial begin
      exp_t       e;
      logic [2:0] a_cnt;
      logic       a_tc, a_busy, a_done;
      forever begin
         @(negedge clk or chk_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
               1:       begin a_cnt = c1_count; a_tc = c1_tc; a_busy = c1_busy; a_done = c1_done; end
               2:       begin a_cnt = c2_count; a_tc = c2_tc; a_busy = c2_busy; a_done = c2_done; end
               default: begin a_cnt = count;    a_tc = tc;    a_busy = busy;    a_done = done;    end
            endcase
            n_tests++;
            if (a_cnt !== e.cnt || a_tc !== e.tc || a_busy !== e.busy || a_done !== e.done) begin
               n_fail++;
               $display("FAIL %s @%0t: got count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b busy=%0b done=%0b",
                        e.name, $time, a_cnt, a_tc, a_busy, a_done, e.cnt, e.tc, e.busy, e.done);
            end
         end
      end
   end

   // One clock cycle on the main instance: drive inputs after the edge and
   // queue the outputs expected during that cycle.
   task automatic cyc(input logic i_en, input logic i_load, input logic [2:0] i_lv,
                      input logic i_os, input logic [2:0] e_cnt, input logic e_tc,
                      input logic e_busy, input logic e_done, input string nm);
      @(posedge clk);
      #1;
      en = i_en; load = i_load; load_val = i_lv; one_shot = i_os;
      push(0, e_cnt, e_tc, e_busy, e_done, nm);
   endtask

   int ar_exp [13] = '{5, 4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5};

   initial begin
      int         ce1, ce2;
      logic [2:0] e1, e2;
      reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 3'd0; one_shot = 1'b0;
      c_load = 1'b0; c_lv = 3'd0; c_os = 1'b0; c1_en = 1'b0;
      #1;
      push(0, 3'd0, 1'b0, 1'b0, 1'b0, "reset_state");
      @(posedge clk);
      #1 reset = 1'b0;

      // IDLE ignores en
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "idle_en_ignored");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "idle_en_ignored2");

      // reset mid-count
      cyc(1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "pre_load5");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, "load5");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, "dec_4");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, "dec_3");
      #6 reset = 1'b1;
      #1;
      push(0, 3'd0, 1'b0, 1'b0, 1'b0, "async_reset_midcycle");
      ->chk_ev;
      @(posedge clk);
      #1 reset = 1'b0;
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "en_after_reset");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "en_after_reset2");

      // auto-reload, en held high
      cyc(1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "ar_load");
      for (int i = 0; i < 13; i++) begin
         cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'(ar_exp[i]), (ar_exp[i] == 0), 1'b1, 1'b0, "auto_reload");
      end

      // one-shot
      cyc(1'b1, 1'b1, 3'd2, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, "os_load2");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, "os_2");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, "os_1");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "os_0_tc");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "os_done");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "os_done_hold_en");
      cyc(1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "os_reload4");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, "os_loaded4");

      // clamp and enable gaps
      cyc(1'b0, 1'b1, 3'd7, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, "clamp_load7");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, "clamp_5");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, "gap_4");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, "gap_hold_4");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, "gap_3");

      // load 0 one-shot, then load priority over tc
      cyc(1'b0, 1'b1, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, "lp_load0");
      cyc(1'b1, 1'b1, 3'd3, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, "lp_tc_with_load");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, "lp_load_wins");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, "lp_3");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, "lp_2");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, "lp_1");
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "lp_0_tc");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "lp_done");

      // clamp boundary: n = 6 -> 6 clamps to 5
      cyc(1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "clamp_load6");
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, "clamp6_to_5");

      // cascade: stage 1 runs every cycle, stage 2 on stage-1 tc
      @(posedge clk);
      #1;
      en = 1'b0; load = 1'b0;
      c_load = 1'b1; c_lv = 3'd5; c_os = 1'b0; c1_en = 1'b1;
      for (int c = 1; c <= 72; c++) begin
         @(posedge clk);
         #1;
         c_load = 1'b0;
         ce1 = 5 - ((c - 1) % 6);
         ce2 = 5 - (((c - 1) / 6) % 6);
         e1  = 3'(ce1);
         e2  = 3'(ce2);
         push(1, e1, (ce1 == 0), 1'b1, 1'b0, "cascade_stage1");
         push(2, e2, (ce1 == 0) && (ce2 == 0), 1'b1, 1'b0, "cascade_stage2");
      end

      @(negedge clk);
      #1;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
